// File: rtl/hazard_ctrl_pkg.sv
// Shared sizes, scoreboard latencies and the per-cycle ID decision type for
// the hazard interlock.
`timescale 1ns/1ps
package hazard_ctrl_pkg;

    localparam int WB_LAT       = 3;
    localparam int LD_EXTRA     = 2;
    localparam int NUM_GP       = 16;
    localparam int NUM_SR       = 4;
    localparam int FLUSH_CYCLES = 2;

    localparam int SIZE_TGT_GP   = $clog2(NUM_GP);
    localparam int SIZE_SRC_GP   = SIZE_TGT_GP;
    localparam int SIZE_TGT_SR   = $clog2(NUM_SR);
    localparam int SIZE_SRC_SR   = SIZE_TGT_SR;
    localparam int SIZE_HZCNT    = $clog2(WB_LAT + LD_EXTRA + 1);
    localparam int SIZE_STALLCNT = 16;
    localparam int SIZE_FLUSHCNT = $clog2(FLUSH_CYCLES + 1);

    typedef logic [SIZE_HZCNT-1:0] hzcnt_t;

    // What happens to the instruction held in ID this cycle.
    typedef enum logic [1:0] {
        DEC_IDLE,
        DEC_ISSUE,
        DEC_STALL,
        DEC_SQUASH
    } id_dec_e;

    // Loads become visible LD_EXTRA cycles later than ALU results.
    function automatic hzcnt_t gp_load_val(input logic is_load);
        return is_load ? hzcnt_t'(WB_LAT + LD_EXTRA) : hzcnt_t'(WB_LAT);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode-to-interlock bundle: decoded operand fields in, issue/stall/flush
// decisions and scoreboard status out.
`timescale 1ns/1ps
interface hazard_ctrl_if
    import hazard_ctrl_pkg::*;
();

    logic                     iw_id_valid;
    logic [SIZE_SRC_GP-1:0]   iw_src_gp;
    logic                     iw_src_gp_en;
    logic [SIZE_TGT_GP-1:0]   iw_tgt_gp;
    logic                     iw_tgt_gp_we;
    logic                     iw_tgt_gp_rd;
    logic [SIZE_SRC_SR-1:0]   iw_src_sr;
    logic                     iw_src_sr_en;
    logic [SIZE_TGT_SR-1:0]   iw_tgt_sr;
    logic                     iw_tgt_sr_we;
    logic                     iw_is_load;
    logic                     iw_sets_flags;
    logic                     iw_uses_flags;
    logic                     iw_branch_taken;

    logic                     ow_issue;
    logic                     ow_stall;
    logic                     ow_flush;
    logic [NUM_GP-1:0]        ow_busy_gp;
    logic [SIZE_STALLCNT-1:0] ow_stall_cnt;

    modport master (
        output iw_id_valid, iw_src_gp, iw_src_gp_en, iw_tgt_gp, iw_tgt_gp_we,
               iw_tgt_gp_rd, iw_src_sr, iw_src_sr_en, iw_tgt_sr, iw_tgt_sr_we,
               iw_is_load, iw_sets_flags, iw_uses_flags, iw_branch_taken,
        input  ow_issue, ow_stall, ow_flush, ow_busy_gp, ow_stall_cnt
    );

    modport slave (
        input  iw_id_valid, iw_src_gp, iw_src_gp_en, iw_tgt_gp, iw_tgt_gp_we,
               iw_tgt_gp_rd, iw_src_sr, iw_src_sr_en, iw_tgt_sr, iw_tgt_sr_we,
               iw_is_load, iw_sets_flags, iw_uses_flags, iw_branch_taken,
        output ow_issue, ow_stall, ow_flush, ow_busy_gp, ow_stall_cnt
    );

endinterface

// File: rtl/hazard_ctrl_cnt.sv
// One scoreboard entry: a loadable down-counter that stops at zero and flags
// the entry busy while a write is still in flight.
`timescale 1ns/1ps
module hazard_ctrl_cnt
    import hazard_ctrl_pkg::*;
(
    input  logic   i_clk,
    input  logic   i_rst,
    input  logic   i_load,
    input  hzcnt_t i_load_val,
    output logic   o_busy
);

    hzcnt_t r_cnt;

    // A fresh reservation takes priority over draining the old one.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - hzcnt_t'(1);
        end
    end

    assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline interlock between ID and EX: countdown scoreboard for GP, SR and
// flag writes, issue/stall/squash decision and branch flush sequencing.
`timescale 1ns/1ps
module hazard_ctrl
    import hazard_ctrl_pkg::*;
(
    input  logic         iw_clk,
    input  logic         iw_rst,
    hazard_ctrl_if.slave io_hz
);

    genvar gi;

    logic [NUM_GP-1:0]        w_busy_gp;
    logic [NUM_SR-1:0]        w_busy_sr;
    logic                     w_busy_flags;
    logic                     w_hazard;
    logic                     w_squash;
    logic                     w_issue;
    logic                     w_stall;
    id_dec_e                  w_dec;
    hzcnt_t                   w_gp_load_val;
    logic [SIZE_FLUSHCNT-1:0] w_flush_cnt_next;
    logic [SIZE_FLUSHCNT-1:0] r_flush_cnt;
    logic                     r_flush;
    logic [SIZE_STALLCNT-1:0] r_stall_cnt;

    assign w_gp_load_val = gp_load_val(io_hz.iw_is_load);

    generate
        for (gi = 0; gi < NUM_GP; gi++) begin : g_gp
            hazard_ctrl_cnt u_cnt (
                .i_clk      (iw_clk),
                .i_rst      (iw_rst),
                .i_load     (w_issue & io_hz.iw_tgt_gp_we &
                             (io_hz.iw_tgt_gp == SIZE_TGT_GP'(gi))),
                .i_load_val (w_gp_load_val),
                .o_busy     (w_busy_gp[gi])
            );
        end

        for (gi = 0; gi < NUM_SR; gi++) begin : g_sr
            hazard_ctrl_cnt u_cnt (
                .i_clk      (iw_clk),
                .i_rst      (iw_rst),
                .i_load     (w_issue & io_hz.iw_tgt_sr_we &
                             (io_hz.iw_tgt_sr == SIZE_TGT_SR'(gi))),
                .i_load_val (hzcnt_t'(WB_LAT)),
                .o_busy     (w_busy_sr[gi])
            );
        end
    endgenerate

    hazard_ctrl_cnt u_flags_cnt (
        .i_clk      (iw_clk),
        .i_rst      (iw_rst),
        .i_load     (w_issue & io_hz.iw_sets_flags),
        .i_load_val (hzcnt_t'(WB_LAT)),
        .o_busy     (w_busy_flags)
    );

    // A busy write target also stalls, so a short-latency write can never
    // overtake an older load to the same register.
    always_comb begin
        w_hazard = 1'b0;
        if (io_hz.iw_src_gp_en && w_busy_gp[io_hz.iw_src_gp]) begin
            w_hazard = 1'b1;
        end
        if ((io_hz.iw_tgt_gp_rd || io_hz.iw_tgt_gp_we) && w_busy_gp[io_hz.iw_tgt_gp]) begin
            w_hazard = 1'b1;
        end
        if (io_hz.iw_src_sr_en && w_busy_sr[io_hz.iw_src_sr]) begin
            w_hazard = 1'b1;
        end
        if (io_hz.iw_tgt_sr_we && w_busy_sr[io_hz.iw_tgt_sr]) begin
            w_hazard = 1'b1;
        end
        if (io_hz.iw_uses_flags && w_busy_flags) begin
            w_hazard = 1'b1;
        end
    end

    assign w_squash = io_hz.iw_branch_taken | r_flush;

    always_comb begin
        w_dec = DEC_IDLE;
        if (io_hz.iw_id_valid) begin
            if (w_squash) begin
                w_dec = DEC_SQUASH;
            end else if (w_hazard) begin
                w_dec = DEC_STALL;
            end else begin
                w_dec = DEC_ISSUE;
            end
        end
    end

    assign w_issue = (w_dec == DEC_ISSUE);
    assign w_stall = (w_dec == DEC_STALL);

    // Another taken branch inside an open window restarts it.
    always_comb begin
        w_flush_cnt_next = r_flush_cnt;
        if (io_hz.iw_branch_taken) begin
            w_flush_cnt_next = SIZE_FLUSHCNT'(FLUSH_CYCLES);
        end else if (r_flush_cnt != '0) begin
            w_flush_cnt_next = r_flush_cnt - SIZE_FLUSHCNT'(1);
        end
    end

    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            r_flush_cnt <= '0;
            r_flush     <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_flush_cnt <= w_flush_cnt_next;
            r_flush     <= (w_flush_cnt_next != '0);
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + SIZE_STALLCNT'(1);
            end
        end
    end

    assign io_hz.ow_issue     = w_issue;
    assign io_hz.ow_stall     = w_stall;
    assign io_hz.ow_flush     = r_flush;
    assign io_hz.ow_busy_gp   = w_busy_gp;
    assign io_hz.ow_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a timestamp scoreboard model checked every
// cycle, plus literal expectations for each scenario.
`timescale 1ns/1ps
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    hazard_ctrl_if hzi ();

    hazard_ctrl dut (
        .iw_clk (clk),
        .iw_rst (rst),
        .io_hz  (hzi)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
        else
            n_pass++;
    endtask

    // Model: each entry remembers the first cycle at which it is free again.
    int gp_ready [NUM_GP];
    int sr_ready [NUM_SR];
    int flag_ready  = 0;
    int flush_end   = 0;
    int m_stall_cnt = 0;
    int cyc         = 0;
    bit chk_en      = 1'b0;
    logic              e_hz, e_sq, e_issue, e_stall, e_flush;
    logic [NUM_GP-1:0] e_busy;

    always @(negedge clk) begin
        e_hz = (hzi.iw_src_gp_en && cyc < gp_ready[hzi.iw_src_gp])
            || ((hzi.iw_tgt_gp_rd || hzi.iw_tgt_gp_we) && cyc < gp_ready[hzi.iw_tgt_gp])
            || (hzi.iw_src_sr_en && cyc < sr_ready[hzi.iw_src_sr])
            || (hzi.iw_tgt_sr_we && cyc < sr_ready[hzi.iw_tgt_sr])
            || (hzi.iw_uses_flags && cyc < flag_ready);
        e_flush = (cyc < flush_end);
        e_sq    = hzi.iw_branch_taken || e_flush;
        e_issue = hzi.iw_id_valid && !e_sq && !e_hz;
        e_stall = hzi.iw_id_valid && !e_sq && e_hz;
        for (int r = 0; r < NUM_GP; r++) e_busy[r] = (cyc < gp_ready[r]);
        if (chk_en) begin
            chk("m_issue", 32'(hzi.ow_issue), 32'(e_issue));
            chk("m_stall", 32'(hzi.ow_stall), 32'(e_stall));
            chk("m_flush", 32'(hzi.ow_flush), 32'(e_flush));
            chk("m_busy_gp", 32'(hzi.ow_busy_gp), 32'(e_busy));
            chk("m_stall_cnt", 32'(hzi.ow_stall_cnt), m_stall_cnt);
        end
        if (rst) begin
            for (int r = 0; r < NUM_GP; r++) gp_ready[r] = 0;
            for (int r = 0; r < NUM_SR; r++) sr_ready[r] = 0;
            flag_ready  = 0;
            flush_end   = 0;
            m_stall_cnt = 0;
            chk_en      = 1'b1;
        end else begin
            if (e_issue) begin
                if (hzi.iw_tgt_gp_we)
                    gp_ready[hzi.iw_tgt_gp] = cyc + 1 + (hzi.iw_is_load ? WB_LAT + LD_EXTRA : WB_LAT);
                if (hzi.iw_tgt_sr_we) sr_ready[hzi.iw_tgt_sr] = cyc + 1 + WB_LAT;
                if (hzi.iw_sets_flags) flag_ready = cyc + 1 + WB_LAT;
            end
            if (hzi.iw_branch_taken) flush_end = cyc + 1 + FLUSH_CYCLES;
            if (e_stall && m_stall_cnt < 65535) m_stall_cnt++;
        end
        cyc++;
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input int sg, input bit sge, input int tg, input bit twe,
                         input bit trd, input int ss, input bit sse, input int ts, input bit tswe,
                         input bit ld, input bit sf, input bit uf);
        hzi.iw_id_valid   = v;
        hzi.iw_src_gp     = SIZE_SRC_GP'(sg);
        hzi.iw_src_gp_en  = sge;
        hzi.iw_tgt_gp     = SIZE_TGT_GP'(tg);
        hzi.iw_tgt_gp_we  = twe;
        hzi.iw_tgt_gp_rd  = trd;
        hzi.iw_src_sr     = SIZE_SRC_SR'(ss);
        hzi.iw_src_sr_en  = sse;
        hzi.iw_tgt_sr     = SIZE_TGT_SR'(ts);
        hzi.iw_tgt_sr_we  = tswe;
        hzi.iw_is_load    = ld;
        hzi.iw_sets_flags = sf;
        hzi.iw_uses_flags = uf;
    endtask

    // Leaves the bench at the negedge of the issue cycle (or after the bound).
    task automatic run_until_issue(input int idx, output int stalls, output int busy_hi);
        stalls  = 0;
        busy_hi = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (hzi.ow_stall) stalls++;
            if (hzi.ow_busy_gp[idx]) busy_hi++;
            if (hzi.ow_issue) break;
            next();
        end
    endtask

    task automatic issue_one(input string name);
        @(negedge clk);
        chk(name, 32'(hzi.ow_issue), 32'd1);
        next();
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    int st, bh, fcnt;

    initial begin
        hzi.iw_branch_taken = 1'b0;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        next();
        next();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_issue", 32'(hzi.ow_issue), 32'd1);
        chk("rst_stall", 32'(hzi.ow_stall), 32'd0);
        chk("rst_flush", 32'(hzi.ow_flush), 32'd0);
        chk("rst_busy", 32'(hzi.ow_busy_gp), 32'd0);
        chk("rst_stall_cnt", 32'(hzi.ow_stall_cnt), 32'd0);
        next();

        // ADD r1 then a reader of r1
        drive(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        issue_one("add_issue");
        drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        run_until_issue(1, st, bh);
        chk("add_stalls", st, 32'd3);
        chk("add_busy1", bh, 32'd3);
        chk("add_stall_cnt", 32'(hzi.ow_stall_cnt), 32'd3);
        next();

        // LD r2 then reader of r2; LD r2 then unrelated reader of r3
        drive(1, 0, 0, 2, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        issue_one("ld_issue");
        drive(1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        run_until_issue(2, st, bh);
        chk("ld_stalls", st, 32'd5);
        chk("ld_busy2", bh, 32'd5);
        next();
        drive(1, 0, 0, 2, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        issue_one("ld2_issue");
        drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        run_until_issue(3, st, bh);
        chk("indep_stalls", st, 32'd0);
        next();

        // CMP r4 then BCC; CMP then unconditional branch
        drive(1, 0, 0, 4, 0, 1, 0, 0, 0, 0, 0, 1, 0);
        issue_one("cmp_issue");
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        run_until_issue(0, st, bh);
        chk("bcc_stalls", st, 32'd3);
        next();
        drive(1, 0, 0, 4, 0, 1, 0, 0, 0, 0, 0, 1, 0);
        issue_one("cmp2_issue");
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        run_until_issue(0, st, bh);
        chk("bra_stalls", st, 32'd0);
        next();

        // SR write then SR read; GP index 0 behaves like any other
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        issue_one("sr_wr_issue");
        drive(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        run_until_issue(0, st, bh);
        chk("sr_stalls", st, 32'd3);
        next();
        drive(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        issue_one("r0_wr_issue");
        drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        run_until_issue(0, st, bh);
        chk("r0_stalls", st, 32'd3);
        chk("r0_busy", bh, 32'd3);
        next();

        // Taken branch while a reader of r5 is stalled
        drive(1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        issue_one("br_add_issue");
        drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("br_pre_stall", 32'(hzi.ow_stall), 32'd1);
        next();
        hzi.iw_branch_taken = 1'b1;
        @(negedge clk);
        chk("br_cyc_stall", 32'(hzi.ow_stall), 32'd0);
        chk("br_cyc_issue", 32'(hzi.ow_issue), 32'd0);
        next();
        hzi.iw_branch_taken = 1'b0;
        @(negedge clk);
        chk("br_f1_flush", 32'(hzi.ow_flush), 32'd1);
        chk("br_f1_busy5", 32'(hzi.ow_busy_gp[5]), 32'd1);
        chk("br_f1_issue", 32'(hzi.ow_issue), 32'd0);
        next();
        @(negedge clk);
        chk("br_f2_flush", 32'(hzi.ow_flush), 32'd1);
        chk("br_f2_busy5", 32'(hzi.ow_busy_gp[5]), 32'd0);
        chk("br_f2_issue", 32'(hzi.ow_issue), 32'd0);
        next();
        @(negedge clk);
        chk("br_end_flush", 32'(hzi.ow_flush), 32'd0);
        chk("br_end_issue", 32'(hzi.ow_issue), 32'd1);
        next();

        // Back-to-back taken branches stretch the window
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        hzi.iw_branch_taken = 1'b1;
        fcnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (hzi.ow_flush) fcnt++;
            next();
            hzi.iw_branch_taken = (i == 0);
        end
        chk("reload_flush_len", fcnt, 32'd3);

        // Reset with r1 and r2 reserved
        drive(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        issue_one("rs_w1_issue");
        drive(1, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        issue_one("rs_w2_issue");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("rs_busy_before", 32'(hzi.ow_busy_gp), 32'h0006);
        next();
        rst = 1'b0;
        @(negedge clk);
        chk("rs_busy_after", 32'(hzi.ow_busy_gp), 32'h0000);
        chk("rs_stall_cnt", 32'(hzi.ow_stall_cnt), 32'd0);
        next();

        // LD r1 <- [r1] forever: five stalls per issue until saturation
        drive(1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        repeat (6) next();
        @(negedge clk);
        chk("sat_first_group", 32'(hzi.ow_stall_cnt), 32'd5);
        repeat (78700) next();
        @(negedge clk);
        chk("sat_reached", 32'(hzi.ow_stall_cnt), 32'hFFFF);
        repeat (12) next();
        @(negedge clk);
        chk("sat_hold", 32'(hzi.ow_stall_cnt), 32'hFFFF);
        next();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline interlock controller between the decode latch and execute. It keeps a countdown scoreboard of in-flight writes to GP registers, SR registers and the condition flags. From the decoded fields it decides each cycle whether the instruction in ID issues, stalls or is squashed. On a taken branch it sequences the front-end flush.

## Interface
- WB_LAT, 3: cycles from issue until a result is architecturally visible (no forwarding).
- LD_EXTRA, 2: additional cycles for LD results.
- NUM_GP, 16: GP registers; index width `SIZE_TGT_GP.
- NUM_SR, 4: SR registers; index width `SIZE_TGT_SR.
- FLUSH_CYCLES, 2: length of the flush window.
- iw_clk  in  1  clock; the only clock.
- iw_rst  in  1  reset, synchronous, active-high.
- iw_id_valid  in  1  ID latch holds a real instruction.
- iw_src_gp, iw_src_gp_en  in  `SIZE_SRC_GP, 1  GP source read.
- iw_tgt_gp, iw_tgt_gp_we, iw_tgt_gp_rd  in  `SIZE_TGT_GP, 1, 1  GP target; write, or read-as-source (CMP/ST).
- iw_src_sr, iw_src_sr_en  in  `SIZE_SRC_SR, 1  SR source read.
- iw_tgt_sr, iw_tgt_sr_we  in  `SIZE_TGT_SR, 1  SR target write.
- iw_is_load  in  1  instruction is LD.
- iw_sets_flags, iw_uses_flags  in  1, 1  CMP-class writer; conditional branch reader.
- iw_branch_taken  in  1  from EX, branch resolved taken this cycle.
- ow_issue  out  1  ID instruction advances to EX this cycle (combinational).
- ow_stall  out  1  hold PC/IF/ID latches and insert a bubble (combinational).
- ow_flush  out  1  registered flush to IF/ID (drives their iw_flush).
- ow_busy_gp  out  NUM_GP  per-register pending bits.
- ow_stall_cnt  out  16  saturating stall-cycle counter.

## Operation
- Countdown counters: one per GP, one per SR, one for flags. Counter width is clog2(WB_LAT+LD_EXTRA+1). An entry is busy while its counter is nonzero.
- hazard = (src_gp_en & busy_gp[src_gp]) | ((tgt_gp_rd | tgt_gp_we) & busy_gp[tgt_gp]) | (src_sr_en & busy_sr[src_sr]) | (tgt_sr_we & busy_sr[tgt_sr]) | (uses_flags & busy_flags). Stalling on a busy write target prevents WAW reordering by loads.
- squash = iw_branch_taken | (flush_cnt != 0).
- ow_issue = id_valid & ~squash & ~hazard.
- ow_stall = id_valid & ~squash & hazard.
- On issue:
  - GP target counter loads WB_LAT, or WB_LAT+LD_EXTRA when is_load.
  - SR target counter loads WB_LAT.
  - Flag counter loads WB_LAT when sets_flags.
- Every other nonzero counter decrements by 1 each cycle. A load and a decrement on the same entry resolve as load wins.
- Flush sequencer:
  - iw_branch_taken loads flush_cnt with FLUSH_CYCLES. A taken branch during an active window reloads it.
  - ow_flush = (flush_cnt != 0), registered.
  - Reservations made before the flush drain normally. Stale wrong-path reservations cannot exist, because squash blocks issue in the branch cycle.
- ow_stall_cnt increments on every cycle with ow_stall=1 and holds at 0xFFFF.

## Timing
- Reset (sync): all counters 0, flush_cnt 0, ow_flush 0, ow_busy_gp 0, ow_stall_cnt 0. ow_issue and ow_stall then follow their combinational equations above.
- Reset mid-operation discards all reservations; the next cycle sees an empty scoreboard.
- Dependent instruction immediately following its producer: stalls exactly WB_LAT cycles, or WB_LAT+LD_EXTRA for LD, then issues.
- Register index 0 is treated like any other register.
- ow_flush rises the cycle after iw_branch_taken and stays high FLUSH_CYCLES cycles. Issue is possible in the first cycle after it falls.
- iw_id_valid=0: ow_issue=0 and ow_stall=0; counters keep draining.

## Structure
- Sizes and opcode constants come from src/sizes.vh and src/opcodes.vh.
- Add `SIZE_HZCNT (counter width) and `SIZE_STALLCNT (16) to sizes.vh.
- Sub-module hazard_cnt: one loadable, saturating-at-zero down-counter with busy output. It is instantiated NUM_GP+NUM_SR+1 times via generate.
- Flag decode (sets_flags, uses_flags, is_load, tgt_gp_rd) stays in the decode stage; this block only consumes the bits.

## Test plan
- Reset: assert iw_rst 2 cycles with id_valid=1 and no hazard inputs -> ow_issue=1, ow_stall=0, ow_flush=0, ow_busy_gp=0, ow_stall_cnt=0.
- ADD r1 issues, next instr src_gp=1 -> ow_stall high exactly 3 cycles, ow_busy_gp[1] high 3 cycles, ow_issue on 4th cycle, ow_stall_cnt=3.
- LD r2 then consumer of r2 -> 5 stall cycles; an independent consumer of r3 issues with 0 stall.
- CMP (sets_flags) then BCC (uses_flags=1) -> 3 stalls; unconditional branch with uses_flags=0 -> 0 stalls.
- iw_branch_taken during a stall -> same cycle ow_stall=0 and ow_issue=0; ow_flush high 2 cycles; busy bits continue to count down; issue resumes the cycle after ow_flush drops.
- Reset asserted while ow_busy_gp=0x0006 -> next cycle ow_busy_gp=0; force 70000 stall cycles -> ow_stall_cnt holds 0xFFFF.
